// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM encoding and register constants for pipeline control
package pipeline_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: falling-edge saturating event counter cleared by active-low reset
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(negedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: load-use, branch-flush and memory-freeze sequencer for the 5-stage pipeline
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_WriteRegister,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PC_Enable,
  output logic             IF_ID_Enable,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Enable,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Enable,
  output logic             MEM_WB_Enable,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  state_t     state, state_nx;
  logic [7:0] wait_cnt, wait_nx;
  logic       err_nx, run_eval, load_use;
  assign load_use = ID_EX_MemRead && ID_EX_WriteRegister != REG_ZERO &&
                    (ID_EX_WriteRegister == IF_ID_Rs || ID_EX_WriteRegister == IF_ID_Rt);
  // a branch squashes the ID instruction, so it masks any load-use match
  assign run_eval = (state == RUN && !(MemReq && !MemReady)) || (state == MEM_WAIT && MemReady);
  always_comb begin
    PC_Enable     = 1'b0;
    IF_ID_Enable  = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EX_Enable  = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Enable = 1'b0;
    MEM_WB_Enable = 1'b0;
    if (reset && run_eval) begin
      PC_Enable     = BranchTaken || !load_use;
      IF_ID_Enable  = BranchTaken || !load_use;
      IF_ID_Flush   = BranchTaken;
      ID_EX_Enable  = 1'b1;
      ID_EX_Flush   = BranchTaken || load_use;
      EX_MEM_Enable = 1'b1;
      MEM_WB_Enable = 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    err_nx   = MemError;
    case (state)
      RUN:
        if (MemReq && !MemReady) begin
          state_nx = MEM_WAIT;
          wait_nx  = 8'd1;
        end
      MEM_WAIT:
        if (MemReady) begin
          state_nx = RUN;
          wait_nx  = 8'd0;
        end else begin
          wait_nx = wait_cnt + 8'd1;
          if (wait_nx >= TIMEOUT) begin
            state_nx = ERROR;
            err_nx   = 1'b1;
          end
        end
      default: state_nx = ERROR;
    endcase
  end
  always_ff @(negedge clk or negedge reset)
    if (!reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      MemError <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      MemError <= err_nx;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(!PC_Enable), .count(StallCycles)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(IF_ID_Flush), .count(FlushCount)
  );
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage pipeline. It drives the enable and flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Load-use hazards: inserts one bubble.
- Taken branches: flushes the wrong-path instructions.
- Multi-cycle data RAM: freezes the whole pipeline while the RAM handshake is pending, with a watchdog timeout.
- Performance: keeps saturating stall and flush counters.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before a fatal error; legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  system clock; state updates on the falling edge, like the pipeline registers it drives.
- reset  in  1  asynchronous, active-low reset.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_WriteRegister  in  5  destination register of the instruction in EX.
- IF_ID_Rs  in  5  source register Rs of the instruction in ID.
- IF_ID_Rt  in  5  source register Rt of the instruction in ID.
- BranchTaken  in  1  branch or jump resolved taken in EX.
- MemReq  in  1  EX_MEM stage holds a load or store (MemRead|MemWrite).
- MemReady  in  1  data RAM completes the access this cycle.
- PC_Enable  out  1  enable for the PC.
- IF_ID_Enable  out  1  enable for IF_ID.
- IF_ID_Flush  out  1  flush for IF_ID.
- ID_EX_Enable  out  1  enable for ID_EX.
- ID_EX_Flush  out  1  flush for ID_EX.
- EX_MEM_Enable  out  1  enable for EX_MEM.
- MEM_WB_Enable  out  1  enable for MEM_WB.
- MemError  out  1  sticky flag; RAM timeout occurred.
- StallCycles  out  CNT_W  cycles in which PC_Enable=0 (excluding reset), saturating.
- FlushCount  out  CNT_W  taken-branch flushes, saturating.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset forces RUN, wait counter 0, MemError=0, StallCycles=0, FlushCount=0.
- While reset=0: all enables 0 and all flushes 0.
- Outputs are combinational from state and inputs. Zero-latency stall: a hazard is detected and acted on in the same cycle.
- Priority in RUN, highest first:
  1. Memory stall: MemReq=1 and MemReady=0. All five enables 0, flushes 0; next state MEM_WAIT, wait counter <- 1.
  2. Branch: BranchTaken=1. All enables 1, IF_ID_Flush=1, ID_EX_Flush=1; FlushCount+1. Any load-use match is ignored because the ID instruction is squashed.
  3. Load-use: ID_EX_MemRead=1, ID_EX_WriteRegister!=0, and it equals IF_ID_Rs or IF_ID_Rt. PC_Enable=0, IF_ID_Enable=0, ID_EX_Enable=1, ID_EX_Flush=1, EX_MEM_Enable=1, MEM_WB_Enable=1.
  4. Otherwise: all enables 1, flushes 0.
- MEM_WAIT:
  - MemReady=0: all enables 0; wait counter +1. When the counter reaches MEM_TIMEOUT, next state ERROR and MemError <- 1.
  - MemReady=1: outputs are evaluated exactly as in RUN rules 2-4 (a branch held in EX is honoured now); next state RUN.
- ERROR: all enables 0, flushes 0. Only reset leaves this state. MemError stays 1.
- Frozen MEM_WB repeats its writeback of identical data; this is idempotent and accepted.
- StallCycles increments on every clock edge where PC_Enable=0 and reset=1; it holds at 2^CNT_W-1. FlushCount saturates the same way.
- A mid-operation reset aborts MEM_WAIT or ERROR immediately; no pending state survives.

Decomposition:
- Shared package pipeline_pkg: FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2) and register index REG_ZERO=5'd0.
- One natural sub-module: sat_counter (CNT_W, inc, clear-on-reset), instantiated twice for StallCycles and FlushCount.
- Load-use compare stays inline.

Test Plan:
1. Load-use: ID_EX_MemRead=1, ID_EX_WriteRegister=8, IF_ID_Rs=8 for one cycle -> PC_Enable=0, IF_ID_Enable=0, ID_EX_Flush=1 that cycle; StallCycles=1.
2. Zero-register exemption: same as scenario 1 but ID_EX_WriteRegister=0, IF_ID_Rt=0 -> no stall, all enables 1.
3. Branch with simultaneous load-use (BranchTaken=1, Rs match) -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Enable=1; FlushCount=1; StallCycles=0.
4. MemReq=1, MemReady=0 for 3 cycles then MemReady=1 -> enables 0 for 3 cycles, all 1 on the 4th; state returns to RUN; StallCycles=3.
5. MEM_TIMEOUT=4, MemReady held 0 -> ERROR after 4 cycles, MemError=1, enables stuck 0. Assert reset=0 mid-ERROR -> RUN, MemError=0, counters 0.
6. Saturation: CNT_W=4, 20 stall cycles -> StallCycles=15.
